obi_axi_fifo_tx: RTL and testbench
==================================

// Module: obi_axi_fifo_tx
// PURPOSE
//  Transmit-side counterpart of the serial-link receive FIFO: CPU-facing OBI slave that buffers 32-bit words in a FIFO
//  and drains them as single-beat AXI4 write bursts into the serial link, whose far end feeds the receive FIFO.
//  Sits between the system bus (OBI slave) and the serial-link AXI slave port; one outstanding AXI write at a time.
// PARAMETERS
//  DATA_WIDTH   32            OBI/AXI data width (AXI strobe = DATA_WIDTH/8)
//  ADDR_WIDTH   32            OBI/AXI address width
//  FIFO_DEPTH   8             TX FIFO depth in words (power of two, >=2)
//  TX_ADDR      32'h0         AXI write address issued for every word (remote receive-FIFO address)
// PORTS
//  clk_i          in   1             clock
//  rst_ni         in   1             asynchronous, active-low reset
//  req_i          in   1             OBI request
//  gnt_o          out  1             OBI grant
//  rvalid_o       out  1             OBI response valid
//  addr_i         in   ADDR_WIDTH    OBI address; bit[2] selects register (0: DATA, 1: STATUS)
//  we_i           in   1             OBI write enable
//  be_i           in   4             OBI byte enable (forwarded as w_strb)
//  wdata_i        in   DATA_WIDTH    OBI write data
//  rdata_o        out  DATA_WIDTH    OBI read data
//  aw_valid_o     out  1             AXI AW valid
//  aw_ready_i     in   1             AXI AW ready
//  aw_addr_o      out  ADDR_WIDTH    AXI AW address (= TX_ADDR; len=0, size=log2(DATA_WIDTH/8), burst INCR)
//  w_valid_o      out  1             AXI W valid
//  w_ready_i      in   1             AXI W ready
//  w_data_o       out  DATA_WIDTH    AXI W data (FIFO head)
//  w_strb_o       out  DATA_WIDTH/8  AXI W strobe (stored with data)
//  w_last_o       out  1             AXI W last, tied 1
//  b_valid_i      in   1             AXI B valid
//  b_ready_o      out  1             AXI B ready
//  b_resp_i       in   2             AXI B response
//  fifo_empty_o   out  1             TX FIFO empty
//  fifo_full_o    out  1             TX FIFO full
//  err_o          out  1             sticky AXI error flag
// BEHAVIOUR
//  Reset: all outputs 0 except fifo_empty_o=1; FSM=IDLE; FIFO empty; err sticky=0; rdata_o=0.
//  OBI: gnt_o = req_i & ~(we_i & addr[2]==0 & full). Accepted access -> rvalid_o exactly 1 cycle later, rdata_o valid then.
//   Write DATA (addr[2]=0): push {be_i,wdata_i}; never granted when full (no push-through on same-cycle pop).
//   Write STATUS (addr[2]=1): wdata_i[0]=1 clears err; other bits ignored.
//   Read DATA: returns 0. Read STATUS: {.., count[N+8:8], busy[3], err[2], full[1], empty[0]}, count = FIFO_DEPTH-wide occupancy $clog2(FIFO_DEPTH+1) bits.
//  FIFO: 1-cycle push-to-visible; simultaneous push and pop when neither full nor empty -> count unchanged.
//  AXI FSM (registered state, outputs decoded from state):
//   IDLE : ~empty -> AW; else stay.
//   AW   : aw_valid_o=1; aw_ready_i -> W. aw_valid held until handshake, address stable.
//   W    : w_valid_o=1, w_data_o/w_strb_o = FIFO head (stable, no pop until handshake); w_ready_i -> pop, -> B.
//   B    : b_ready_o=1; b_valid_i -> IDLE; if b_resp_i!=2'b00 set err (sticky). Word is not retried.
//  busy = (state!=IDLE). Min throughput: one word per 4 cycles with always-ready slave (IDLE,AW,W,B).
//  Simultaneous error set (B handshake w/ error) and software clear in same cycle: set wins.
//  Reset mid-transaction: FSM returns IDLE, FIFO flushed, in-flight AXI handshake abandoned (both sides reset together).
// TESTING
//  1) Reset -> fifo_empty_o=1, aw/w_valid_o=0, b_ready_o=0, STATUS read = 32'h1.
//  2) OBI write 32'hCAFE_0001 be=4'hF, slave always ready -> AW at TX_ADDR, W data CAFE_0001 strb F last=1, B OKAY, err=0, empty.
//  3) 8 writes with aw_ready_i=0 -> 8 grants, full=1, 9th write gnt_o=0 until aw_ready_i released and first W handshake pops.
//  4) w_ready_i stalled 5 cycles -> w_valid_o and w_data_o held stable, count unchanged, pop on handshake cycle only.
//  5) b_resp_i=2'b10 -> err_o=1, STATUS bit2=1; next word still sent; STATUS write 32'h1 -> err_o=0 next cycle.
//  6) Assert rst_ni low while in W with 3 words queued -> after release empty=1, state IDLE, no AXI valid asserted.

Source files
------------

// File: rtl/obi_axi_fifo_tx.sv
// OBI slave that queues CPU write words in a TX FIFO and drains each one as a
// single-beat AXI4 write burst, with one AXI write outstanding at a time.
module obi_axi_fifo_tx #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] TX_ADDR    = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // OBI slave
  input  logic                    req_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  // AXI4 write master
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  // Status
  output logic                    fifo_empty_o,
  output logic                    fifo_full_o,
  output logic                    err_o
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [StrbW-1:0]      strb_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  err_q, err_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] status;

  logic empty, full, sel_status, accept, push, pop, err_set, err_clr;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntW'(FIFO_DEPTH));
  assign sel_status = addr_i[2];

  // A DATA write is refused while full, even if the head pops this cycle.
  assign gnt_o   = req_i & ~(we_i & ~sel_status & full);
  assign accept  = req_i & gnt_o;
  assign push    = accept & we_i & ~sel_status;
  assign pop     = (state_q == StW) & w_ready_i;
  assign err_set = (state_q == StB) & b_valid_i & (b_resp_i != 2'b00);
  assign err_clr = accept & we_i & sel_status & wdata_i[0];

  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:3], addr_i[1:0]};

  always_comb begin
    status             = '0;
    status[0]          = empty;
    status[1]          = full;
    status[2]          = err_q;
    status[3]          = (state_q != StIdle);
    status[8 +: CntW]  = count_q;
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    // Set is applied after clear so a same-cycle AXI error is never lost.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_comb begin
    rvalid_d = accept;
    rdata_d  = (accept & ~we_i & sel_status) ? status : '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty)    state_d = StAw;
      StAw:    if (aw_ready_i) state_d = StW;
      StW:     if (w_ready_i)  state_d = StB;
      StB:     if (b_valid_i)  state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        strb_mem_q[i] <= '0;
      end
    end else if (push) begin
      data_mem_q[wptr_q] <= wdata_i;
      strb_mem_q[wptr_q] <= be_i;
    end
  end

  assign aw_valid_o   = (state_q == StAw);
  assign aw_addr_o    = TX_ADDR;
  assign w_valid_o    = (state_q == StW);
  assign w_data_o     = data_mem_q[rptr_q];
  assign w_strb_o     = strb_mem_q[rptr_q];
  assign w_last_o     = 1'b1;
  assign b_ready_o    = (state_q == StB);
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign fifo_empty_o = empty;
  assign fifo_full_o  = full;
  assign err_o        = err_q;

endmodule

// File: tb/tb_obi_axi_fifo_tx.sv
// Directed bench for obi_axi_fifo_tx: vector table of single-word transfers plus
// hand-written sequences for backpressure, stalls, error clear and reset.
module tb_obi_axi_fifo_tx;

  localparam logic [31:0] TXA = 32'h1000_0040;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, gnt_o, rvalid_o, we_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic [3:0]  be_i;
  logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, w_last_o;
  logic [31:0] aw_addr_o, w_data_o;
  logic [3:0]  w_strb_o;
  logic        b_valid_i, b_ready_o;
  logic [1:0]  b_resp_i;
  logic        fifo_empty_o, fifo_full_o, err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] aw_log[$];
  logic [36:0] w_log[$];

  always #5 clk_i = ~clk_i;

  obi_axi_fifo_tx #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .FIFO_DEPTH(8),
    .TX_ADDR   (TXA)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .aw_valid_o  (aw_valid_o),
    .aw_ready_i  (aw_ready_i),
    .aw_addr_o   (aw_addr_o),
    .w_valid_o   (w_valid_o),
    .w_ready_i   (w_ready_i),
    .w_data_o    (w_data_o),
    .w_strb_o    (w_strb_o),
    .w_last_o    (w_last_o),
    .b_valid_i   (b_valid_i),
    .b_ready_o   (b_ready_o),
    .b_resp_i    (b_resp_i),
    .fifo_empty_o(fifo_empty_o),
    .fifo_full_o (fifo_full_o),
    .err_o       (err_o)
  );

  always @(negedge clk_i) begin
    if (aw_valid_o && aw_ready_i) aw_log.push_back(aw_addr_o);
    if (w_valid_o && w_ready_i) w_log.push_back({w_last_o, w_strb_o, w_data_o});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic obi(input logic we, input logic sel, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic ok);
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = we; addr_i = sel ? 32'h4 : 32'h0; wdata_i = wd; be_i = be;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      ok = gnt_o;
      @(posedge clk_i); #1;
    end
    req_i = 1'b0; we_i = 1'b0;
    if (!ok) check("gnt_timeout", 64'(ok), 64'd1);
    @(negedge clk_i);
    check("rvalid", 64'(rvalid_o), 64'(ok));
    rd = rdata_o;
    @(negedge clk_i);
    check("rvalid_one_cycle", 64'(rvalid_o), 64'd0);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_i);
      done = fifo_empty_o && !aw_valid_o && !w_valid_o && !b_ready_o;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic wait_wvalid(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      seen = w_valid_o;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  resp;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] rd;
  logic        ok, got;

  initial begin
    vecs[0] = '{data: 32'hCAFE_0001, be: 4'hF, resp: 2'b00, exp_err: 1'b0};
    vecs[1] = '{data: 32'h1234_5678, be: 4'h3, resp: 2'b00, exp_err: 1'b0};
    vecs[2] = '{data: 32'hDEAD_BEEF, be: 4'hC, resp: 2'b10, exp_err: 1'b1};
    vecs[3] = '{data: 32'h0BAD_F00D, be: 4'h1, resp: 2'b00, exp_err: 1'b1};
    vecs[4] = '{data: 32'hA5A5_5A5A, be: 4'h5, resp: 2'b11, exp_err: 1'b1};

    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    aw_ready_i = 1'b1; w_ready_i = 1'b1; b_valid_i = 1'b1; b_resp_i = 2'b00;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset state
    @(negedge clk_i);
    check("rst_empty", 64'(fifo_empty_o), 64'd1);
    check("rst_full", 64'(fifo_full_o), 64'd0);
    check("rst_valids", 64'({aw_valid_o, w_valid_o, b_ready_o, rvalid_o}), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);
    obi(1'b0, 1'b1, 32'h0, 4'h0, rd, ok);
    check("rst_status", 64'(rd), 64'h1);
    obi(1'b0, 1'b0, 32'h0, 4'h0, rd, ok);
    check("data_read_zero", 64'(rd), 64'h0);

    // Table of single-word transfers with an always-ready slave
    for (int k = 0; k < 5; k++) begin
      aw_log.delete(); w_log.delete();
      b_resp_i = vecs[k].resp;
      obi(1'b1, 1'b0, vecs[k].data, vecs[k].be, rd, ok);
      wait_idle("vec_idle");
      check("vec_aw_cnt", 64'(aw_log.size()), 64'd1);
      check("vec_w_cnt", 64'(w_log.size()), 64'd1);
      if (aw_log.size() > 0) check("vec_aw_addr", 64'(aw_log[0]), 64'(TXA));
      if (w_log.size() > 0)
        check("vec_w_beat", 64'(w_log[0]), 64'({1'b1, vecs[k].be, vecs[k].data}));
      check("vec_err", 64'(err_o), 64'(vecs[k].exp_err));
      obi(1'b0, 1'b1, 32'h0, 4'h0, rd, ok);
      check("vec_status", 64'(rd), vecs[k].exp_err ? 64'h5 : 64'h1);
    end
    b_resp_i = 2'b00;

    // STATUS write without bit0 keeps err; with bit0 clears it
    obi(1'b1, 1'b1, 32'hFFFF_FFFE, 4'hF, rd, ok);
    check("err_kept", 64'(err_o), 64'd1);
    obi(1'b1, 1'b1, 32'h1, 4'hF, rd, ok);
    check("err_cleared", 64'(err_o), 64'd0);

    // Error set and software clear in the same cycle: set wins
    b_valid_i = 1'b0; b_resp_i = 2'b10;
    obi(1'b1, 1'b0, 32'h7777_0000, 4'hF, rd, ok);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      got = b_ready_o;
    end
    check("reach_b", 64'(got), 64'd1);
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h4; wdata_i = 32'h1; b_valid_i = 1'b1;
    @(negedge clk_i);
    check("clr_gnt", 64'(gnt_o), 64'd1);
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = 1'b0; b_resp_i = 2'b00;
    @(negedge clk_i);
    check("set_wins", 64'(err_o), 64'd1);
    wait_idle("setclr_idle");
    obi(1'b1, 1'b1, 32'h1, 4'hF, rd, ok);
    check("err_cleared2", 64'(err_o), 64'd0);

    // Fill with AW blocked; ninth DATA write waits for the first pop
    aw_log.delete(); w_log.delete();
    aw_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obi(1'b1, 1'b0, 32'h1000_0000 + 32'(i), 4'hF, rd, ok);
      check("fill_gnt", 64'(ok), 64'd1);
    end
    check("full_flag", 64'(fifo_full_o), 64'd1);
    obi(1'b0, 1'b1, 32'h0, 4'h0, rd, ok);
    check("full_status", 64'(rd), 64'h80A);
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'h1000_0008; be_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("full_no_gnt", 64'(gnt_o), 64'd0);
      @(posedge clk_i); #1;
    end
    aw_ready_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      got = gnt_o;
      if (got) check("gnt_after_pop", 64'(w_log.size()), 64'd1);
      @(posedge clk_i); #1;
    end
    req_i = 1'b0; we_i = 1'b0;
    check("ninth_gnt", 64'(got), 64'd1);
    wait_idle("fill_idle");
    check("fill_w_cnt", 64'(w_log.size()), 64'd9);
    for (int i = 0; i < 9; i++)
      if (i < w_log.size()) check("fill_order", 64'(w_log[i][31:0]), 64'(32'h1000_0000 + 32'(i)));

    // W stall: head held stable, no pop until handshake
    w_log.delete();
    w_ready_i = 1'b0;
    obi(1'b1, 1'b0, 32'h5555_AAAA, 4'h6, rd, ok);
    wait_wvalid("stall_wvalid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_hold", 64'({w_valid_o, w_strb_o, w_data_o, fifo_empty_o}),
            64'({1'b1, 4'h6, 32'h5555_AAAA, 1'b0}));
    end
    obi(1'b0, 1'b1, 32'h0, 4'h0, rd, ok);
    check("stall_status", 64'(rd), 64'h108);
    @(posedge clk_i); #1;
    w_ready_i = 1'b1;
    @(negedge clk_i);
    check("no_early_pop", 64'({w_valid_o, fifo_empty_o}), 64'b10);
    @(negedge clk_i);
    check("popped", 64'({w_valid_o, fifo_empty_o, 32'(w_log.size())}), 64'({1'b0, 1'b1, 32'd1}));
    wait_idle("stall_idle");

    // Reset mid-transaction with words queued
    w_log.delete();
    w_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) obi(1'b1, 1'b0, 32'hBEEF_0000 + 32'(i), 4'hF, rd, ok);
    wait_wvalid("mid_wvalid");
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("in_rst", 64'({fifo_empty_o, aw_valid_o, w_valid_o, b_ready_o}), 64'b1000);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; w_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_rst", 64'({fifo_empty_o, aw_valid_o, w_valid_o, b_ready_o}), 64'b1000);
    end
    obi(1'b0, 1'b1, 32'h0, 4'h0, rd, ok);
    check("post_rst_status", 64'(rd), 64'h1);
    check("post_rst_no_w", 64'(w_log.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
